// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, IF/ID payload and occupancy width.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_if_id_payload;

  localparam int PIPE_OCC_W = 2;

  function automatic logic [PIPE_OCC_W-1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot: a valid bit plus a data register with load and clear.
module pipe_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Skid-buffered valid/ready pipeline stage with synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_count output.
module pipe_stage
  import lc3b_types::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic             accept, drain;

  // in_ready comes straight from the skid valid flop, so out_ready never reaches it.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & ~skid_valid;
  assign drain     = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = occ_count(main_valid, skid_valid);

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = in_data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (drain && skid_valid) begin
      main_load = 1'b1;
      main_d    = skid_q;
      if (accept) skid_load  = 1'b1;
      else        skid_clear = 1'b1;
    end else if (drain) begin
      if (accept) main_load  = 1'b1;
      else        main_clear = 1'b1;
    end else if (accept) begin
      if (!main_valid) main_load = 1'b1;
      else             skid_load = 1'b1;
    end
  end

  pipe_entry #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_d),
    .valid   (main_valid),
    .q       (main_q)
  );

  pipe_entry #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (in_data),
    .valid   (skid_valid),
    .q       (skid_q)
  );

`ifdef PIPE_STAGE_PERF_EN
  // Flush is not a reset for the counter; only a flush cycle itself is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (main_valid && !out_ready && !flush && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: directed vectors plus a random valid/ready/flush phase.
module tb_pipe_stage;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_count;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [31:0] mq[$];

  pipe_stage #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares against the reference queue, then advances the queue
  // with what the coming edge will do given the current inputs.
  always @(negedge clk) begin
    int pre;
    if (!reset_n) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_occupancy", {30'b0, occupancy}, 32'd0);
      check("rst_out_data",  out_data,           32'd0);
      mq.delete();
    end else begin
      pre = mq.size();
      check("sb_out_valid", {31'b0, out_valid}, (pre > 0) ? 32'd1 : 32'd0);
      check("sb_in_ready",  {31'b0, in_ready},  (pre < 2) ? 32'd1 : 32'd0);
      check("sb_occupancy", {30'b0, occupancy}, pre);
      if (pre > 0) check("sb_out_data", out_data, mq[0]);
      if (flush) begin
        mq.delete();
      end else begin
        if (pre > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && pre < 2) mq.push_back(in_data);
      end
    end
  end

  initial begin
    // Reset
    step();
    step();
    reset_n = 1'b1;

    // Single payload
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_data",  out_data,           32'h1234_5678);
    check("single_occ1",  {30'b0, occupancy}, 32'd1);
    step();
    check("single_gone",  {31'b0, out_valid}, 32'd0);
    check("single_occ0",  {30'b0, occupancy}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    check("bp_occ2",     {30'b0, occupancy}, 32'd2);
    check("bp_ready0",   {31'b0, in_ready},  32'd0);
    check("bp_head_a",   out_data,           32'hA);
    out_ready = 1'b1;
    step();
    check("bp_head_b",   out_data,           32'hB);
    check("bp_ready1",   {31'b0, in_ready},  32'd1);
    check("bp_occ1",     {30'b0, occupancy}, 32'd1);
    step();
    check("bp_empty",    {31'b0, out_valid}, 32'd0);

    // Full streaming
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1;
      in_data  = k;
      step();
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      check("stream_data",  out_data,           k);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", {31'b0, out_valid}, 32'd0);

    // Flush with both entries full and C offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_data = 32'hC;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_occ",   {30'b0, occupancy}, 32'd0);
    check("flush_ready", {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_no_c", {31'b0, out_valid}, 32'd0);
    end

    // Asynchronous reset between edges with two held payloads
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h33;
    step();
    in_data = 32'h44;
    step();
    in_valid = 1'b0;
    check("arst_pre_occ", {30'b0, occupancy}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_ready", {31'b0, in_ready},  32'd1);
    check("arst_occ",   {30'b0, occupancy}, 32'd0);
    step();
    reset_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    reset_n = 1'b0;
    #1;
    check("perf_rst0", {16'b0, stall_count}, 32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("perf_stall10", {16'b0, stall_count}, 32'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_flush_keep", {16'b0, stall_count}, 32'd10);
    reset_n = 1'b0;
    #1;
    check("perf_rst_clear", {16'b0, stall_count}, 32'd0);
    step();
    reset_n = 1'b1;
`endif

    // Random valid/ready/flush against the reference queue
    for (int k = 0; k < 10000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_data   = $urandom;
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (16-bit PC plus 16-bit IR for IF/ID use).
REQ-002 Parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream has a payload.
REQ-006 in_ready  output  1  stage can accept a payload this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 flush  input  1  synchronous kill of all held payloads (branch redirect).
REQ-009 out_valid  output  1  out_data holds a live payload.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 out_data  output  WIDTH  payload presented downstream.
REQ-012 occupancy  output  2  number of held payloads, 0 to 2.
REQ-013 stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0 (present only under REQ-030).

Function
REQ-014 Storage is two entries: main (drives out_data) and skid; each has its own valid bit.
REQ-015 in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-016 Accept happens when in_valid=1 and in_ready=1; drain happens when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal main_valid, and out_data SHALL equal the main data register.
REQ-018 Latency: an accepted payload appears on out_data on the next clock edge when main is empty or draining in that cycle.
REQ-019 On accept without drain: if main is empty, the payload loads into main; if main is full, it loads into skid.
REQ-020 On drain without accept: skid moves to main if skid is valid; otherwise main_valid clears.
REQ-021 On simultaneous accept and drain: if skid is valid, skid moves to main and the new payload loads into skid; otherwise the new payload loads into main.
REQ-022 Ordering SHALL be strict FIFO, with no payload lost or duplicated.
REQ-023 flush=1 SHALL clear main_valid and skid_valid at the next edge, with priority over accept and drain; any payload accepted in that cycle is discarded.
REQ-024 After a flush, in_ready=1 and occupancy=0 in the following cycle.
REQ-025 occupancy SHALL equal main_valid + skid_valid.
REQ-026 Data registers load only on accept or skid-to-main transfer and hold otherwise.

Reset
REQ-027 While reset_n=0: main_valid=0, skid_valid=0, out_valid=0, in_ready=1, occupancy=0, out_data=0, stall_count=0.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads immediately, regardless of clk.
REQ-029 The first accept SHALL occur no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_EN: when defined, stall_count exists and increments by 1 on each cycle with out_valid=1, out_ready=0 and flush=0.
REQ-031 stall_count SHALL saturate at all-ones and is cleared by reset only, not by flush.
REQ-032 When PIPE_STAGE_PERF_EN is undefined, the stall_count port and counter logic are absent; all other behaviour is identical.

Structure
REQ-033 lc3b_types SHALL gain the typedef lc3b_if_id_payload, a packed struct of pc (lc3b_word) and ir (lc3b_word) whose width is 32.
REQ-034 lc3b_types SHALL gain the constant PIPE_OCC_W = 2.
REQ-035 One sub-module, pipe_entry, SHALL implement the valid bit plus data register with load and clear; pipe_stage instantiates it twice.

Verification
REQ-036 Reset then single payload: in_data=0x12345678, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 with 0x12345678 on the next cycle, then 0, occupancy 1 then 0.
REQ-037 Backpressure: out_ready=0, present A=0xA, then B=0xB -> occupancy=2 and in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 after the A drain.
REQ-038 Full streaming: in_valid=1 and out_ready=1 for 100 cycles with an incrementing payload -> output is the same sequence delayed by 1, with no gaps.
REQ-039 Flush with skid full plus in_valid=1 carrying C -> next cycle out_valid=0, occupancy=0, in_ready=1, and C never appears.
REQ-040 Async reset asserted between edges with occupancy=2 -> out_valid=0 and in_ready=1 immediately; with PIPE_STAGE_PERF_EN, 10 stalled cycles -> stall_count=10, and stall_count=0 after reset.
REQ-041 Random valid/ready/flush against a reference queue model -> zero mismatches over 10,000 cycles.
